// File: rtl/rrv_write_back_pipe.sv
// rrv_write_back_pipe: RRV write-back stage that retires pass-through results and variable-latency loads to the GPR file
//   clk, rst_n                  clock, asynchronous active-low reset
//   valid_mem/ready_mem         instruction handshake from the memory stage
//   load_mem, funct3_mem        load flag and load type
//   gpr_we_mem, addr_rd_mem     destination write enable and register
//   data_rd_mem                 non-load result
//   addr_off_mem                byte offset of the load address within the word
//   rsp_valid, rsp_data         data-memory load response (naturally aligned word)
//   gpr_we_id/addr_rd_id/data_rd_id  registered GPR write port towards decode
//   load_err                    one-cycle pulse for misaligned or illegal loads
//   retire_cnt                  retired-instruction counter, wraps silently
module rrv_write_back_pipe #(
    parameter int XLEN = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_mem,
    output logic                      ready_mem,
    input  logic                      load_mem,
    input  logic [2:0]                funct3_mem,
    input  logic                      gpr_we_mem,
    input  logic [REG_ADDR_WIDTH-1:0] addr_rd_mem,
    input  logic [XLEN-1:0]           data_rd_mem,
    input  logic [OFF_W-1:0]          addr_off_mem,
    input  logic                      rsp_valid,
    input  logic [XLEN-1:0]           rsp_data,
    output logic                      gpr_we_id,
    output logic [REG_ADDR_WIDTH-1:0] addr_rd_id,
    output logic [XLEN-1:0]           data_rd_id,
    output logic                      load_err,
    output logic [CNT_WIDTH-1:0]      retire_cnt
);
    typedef enum logic {IDLE, WAIT_LOAD} state_t;
    state_t state, state_nx;
    logic accept, complete, waiting, is_load, legal, we_src, we_c, err_c;
    logic [2:0] f3_c, f3_q;
    logic [REG_ADDR_WIDTH-1:0] rd_c, rd_q;
    logic [OFF_W-1:0] off_c, off_q;
    logic we_q;
    logic [XLEN-1:0] lane, ext, data_c;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // While waiting, the memory-stage inputs already belong to the next
    // instruction, so the load is finished from the latched copies.
    always_comb begin
        waiting   = state == WAIT_LOAD;
        ready_mem = !waiting;
        accept    = valid_mem & ready_mem;
        complete  = accept ? (!load_mem | rsp_valid) : (waiting & rsp_valid);
        state_nx  = (accept & load_mem & !rsp_valid) ? WAIT_LOAD : complete ? IDLE : state;
        is_load   = waiting | load_mem;
        f3_c      = waiting ? f3_q : funct3_mem;
        rd_c      = waiting ? rd_q : addr_rd_mem;
        off_c     = waiting ? off_q : addr_off_mem;
        we_src    = waiting ? we_q : gpr_we_mem;
        lane      = rsp_data >> {off_c, 3'b000};
        legal     = 1'b0;
        ext       = '0;
        case (f3_c)
            3'b000: begin legal = 1'b1;                          ext = XLEN'($signed(lane[7:0]));  end
            3'b001: begin legal = !off_c[0];                     ext = XLEN'($signed(lane[15:0])); end
            3'b010: begin legal = off_c[1:0] == 2'b00;           ext = XLEN'($signed(lane[31:0])); end
            3'b100: begin legal = 1'b1;                          ext = XLEN'(lane[7:0]);           end
            3'b101: begin legal = !off_c[0];                     ext = XLEN'(lane[15:0]);          end
            3'b110: begin legal = XLEN == 64 && off_c[1:0] == 2'b00; ext = XLEN'(lane[31:0]);     end
            3'b011: begin legal = XLEN == 64 && off_c == '0;     ext = lane;                       end
            default: begin legal = 1'b0;                         ext = '0;                         end
        endcase
        we_c   = we_src & (rd_c != '0) & (!is_load | legal);
        err_c  = is_load & !legal;
        data_c = !is_load ? data_rd_mem : legal ? ext : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            f3_q       <= '0;
            rd_q       <= '0;
            off_q      <= '0;
            we_q       <= 1'b0;
            gpr_we_id  <= 1'b0;
            load_err   <= 1'b0;
            addr_rd_id <= '0;
            data_rd_id <= '0;
            retire_cnt <= '0;
        end else begin
            if (accept & load_mem & !rsp_valid) begin
                f3_q  <= funct3_mem;
                rd_q  <= addr_rd_mem;
                off_q <= addr_off_mem;
                we_q  <= gpr_we_mem;
            end
            gpr_we_id <= complete & we_c;
            load_err  <= complete & err_c;
            if (complete) begin
                addr_rd_id <= rd_c;
                data_rd_id <= data_c;
                retire_cnt <= retire_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_rrv_write_back_pipe.sv
// tb_rrv_write_back_pipe: directed checks of the write-back stage at XLEN=32 (4-bit counter) and XLEN=64
module tb_rrv_write_back_pipe;
    logic clk = 1'b0, rst_n = 1'b0;
    logic v32 = 0, v64 = 0, ld = 0, we_in = 0, rsp_v = 0;
    logic [2:0] f3 = '0;
    logic [4:0] rd = '0;
    logic [31:0] d32_in = '0, rsp32 = '0;
    logic [1:0] off32 = '0;
    logic [63:0] d64_in = '0, rsp64 = '0;
    logic [2:0] off64 = '0;
    logic r32, we32, err32, r64, we64, err64;
    logic [4:0] ard32, ard64;
    logic [31:0] dat32, cnt64;
    logic [63:0] dat64;
    logic [3:0] cnt32;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rrv_write_back_pipe #(.XLEN(32), .CNT_WIDTH(4)) d32 (
        .clk(clk), .rst_n(rst_n), .valid_mem(v32), .ready_mem(r32), .load_mem(ld),
        .funct3_mem(f3), .gpr_we_mem(we_in), .addr_rd_mem(rd), .data_rd_mem(d32_in),
        .addr_off_mem(off32), .rsp_valid(rsp_v), .rsp_data(rsp32), .gpr_we_id(we32),
        .addr_rd_id(ard32), .data_rd_id(dat32), .load_err(err32), .retire_cnt(cnt32));

    rrv_write_back_pipe #(.XLEN(64)) d64 (
        .clk(clk), .rst_n(rst_n), .valid_mem(v64), .ready_mem(r64), .load_mem(ld),
        .funct3_mem(f3), .gpr_we_mem(we_in), .addr_rd_mem(rd), .data_rd_mem(d64_in),
        .addr_off_mem(off64), .rsp_valid(rsp_v), .rsp_data(rsp64), .gpr_we_id(we64),
        .addr_rd_id(ard64), .data_rd_id(dat64), .load_err(err64), .retire_cnt(cnt64));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put32(input logic l, input logic [2:0] f, input logic [4:0] a,
                         input logic [31:0] d, input logic [1:0] o, input logic rv, input logic [31:0] rdat);
        v32 = 1; ld = l; f3 = f; we_in = 1; rd = a; d32_in = d; off32 = o; rsp_v = rv; rsp32 = rdat;
        tick;
        v32 = 0; rsp_v = 0;
    endtask

    task automatic put64(input logic l, input logic [2:0] f, input logic [4:0] a,
                         input logic [63:0] d, input logic [2:0] o, input logic rv, input logic [63:0] rdat);
        v64 = 1; ld = l; f3 = f; we_in = 1; rd = a; d64_in = d; off64 = o; rsp_v = rv; rsp64 = rdat;
        tick;
        v64 = 0; rsp_v = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", we32, 0);
        check("rst_rd", ard32, 0);
        check("rst_data", dat32, 0);
        check("rst_err", err32, 0);
        check("rst_cnt", cnt32, 0);
        check("rst_ready", r32, 1);
        rst_n = 1;
        tick;

        put32(0, 3'b000, 5'd5, 32'h1234_5678, 2'd0, 0, 32'h0);
        check("pass_we", we32, 1);
        check("pass_rd", ard32, 5);
        check("pass_data", dat32, 32'h1234_5678);
        check("pass_cnt", cnt32, 1);
        tick;
        check("pass_we_pulse", we32, 0);
        check("pass_data_hold", dat32, 32'h1234_5678);

        put32(1, 3'b000, 5'd6, 32'h0, 2'd3, 1, 32'h8000_0000);
        check("lb_we", we32, 1);
        check("lb_data", dat32, 32'hFFFF_FF80);
        put32(1, 3'b100, 5'd6, 32'h0, 2'd3, 1, 32'h8000_0000);
        check("lbu_data", dat32, 32'h0000_0080);
        check("lbu_cnt", cnt32, 3);

        v32 = 1; ld = 1; f3 = 3'b001; we_in = 1; rd = 5'd3; off32 = 2'd2; rsp_v = 0;
        tick;
        ld = 0; rd = 5'd7; d32_in = 32'h0000_AAAA; off32 = 2'd0; f3 = 3'b000;
        check("lh_ready0", r32, 0);
        for (int i = 1; i <= 3; i++) begin
            tick;
            check($sformatf("lh_ready%0d", i), r32, 0);
            check($sformatf("lh_we%0d", i), we32, 0);
        end
        rsp_v = 1; rsp32 = 32'hBEEF_0000;
        tick;
        rsp_v = 0;
        check("lh_we", we32, 1);
        check("lh_rd", ard32, 3);
        check("lh_data", dat32, 32'hFFFF_BEEF);
        check("lh_ready_back", r32, 1);
        check("lh_cnt", cnt32, 4);
        tick;
        v32 = 0;
        check("held_pass_we", we32, 1);
        check("held_pass_rd", ard32, 7);
        check("held_pass_data", dat32, 32'h0000_AAAA);
        check("held_pass_cnt", cnt32, 5);

        put32(1, 3'b010, 5'd4, 32'h0, 2'd1, 1, 32'h1111_2222);
        check("lw_mis_err", err32, 1);
        check("lw_mis_we", we32, 0);
        check("lw_mis_data", dat32, 0);
        check("lw_mis_cnt", cnt32, 6);
        tick;
        check("err_pulse", err32, 0);
        put32(1, 3'b011, 5'd4, 32'h0, 2'd0, 1, 32'h1111_2222);
        check("ld32_err", err32, 1);
        check("ld32_we", we32, 0);
        check("ld32_cnt", cnt32, 7);

        put32(0, 3'b000, 5'd0, 32'h0000_0055, 2'd0, 0, 32'h0);
        check("x0_we", we32, 0);
        check("x0_data", dat32, 32'h0000_0055);
        check("x0_cnt", cnt32, 8);

        put64(1, 3'b110, 5'd9, 64'h0, 3'd4, 1, 64'hDEAD_BEEF_0000_0000);
        check("lwu64_we", we64, 1);
        check("lwu64_data", dat64, 64'h0000_0000_DEAD_BEEF);
        put64(1, 3'b011, 5'd9, 64'h0, 3'd0, 1, 64'h0123_4567_89AB_CDEF);
        check("ld64_data", dat64, 64'h0123_4567_89AB_CDEF);
        check("ld64_err", err64, 0);
        put64(1, 3'b010, 5'd9, 64'h0, 3'd0, 1, 64'h0000_0000_8000_0000);
        check("lw64_sext", dat64, 64'hFFFF_FFFF_8000_0000);
        check("cnt64", cnt64, 3);
        check("idle32_cnt", cnt32, 8);

        put32(1, 3'b000, 5'd2, 32'h0, 2'd0, 0, 32'h0);
        check("wait_ready", r32, 0);
        rst_n = 0;
        #1;
        check("arst_ready", r32, 1);
        check("arst_we", we32, 0);
        check("arst_rd", ard32, 0);
        check("arst_data", dat32, 0);
        check("arst_cnt", cnt32, 0);
        tick;
        rst_n = 1;
        rsp_v = 1; rsp32 = 32'h0000_00FF;
        tick;
        rsp_v = 0;
        check("late_rsp_we", we32, 0);
        check("late_rsp_cnt", cnt32, 0);
        check("late_rsp_ready", r32, 1);

        v32 = 1; ld = 0; rd = 5'd1; we_in = 1; d32_in = 32'h1;
        repeat (15) tick;
        check("cnt_15", cnt32, 4'hF);
        tick;
        v32 = 0;
        check("cnt_wrap", cnt32, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
